// File: rtl/azimuth_pkg.sv
// Shared definitions for the azimuth pattern generator: FSM state
// encoding, a constant-evaluable clog2 and the default geometry.
package azimuth_pkg;

  localparam int unsigned AZ_SIZE  = 3200;
  localparam int unsigned AZ_DIV_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } az_state_e;

  // Number of bits needed to index 'value' entries (value >= 2)
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/azimuth_prescaler.sv
// Bit-rate prescaler: counts 0..div_q while enabled and ticks on the last
// count, so each bit period lasts div_q+1 clocks. 'load' restarts the count
// and latches a new divide value; 'clr' restarts the count only.
module azimuth_prescaler
  import azimuth_pkg::*;
#(
  parameter int unsigned DIV_W = AZ_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = en & (cnt == div_q);

  // Period counter with divide-value latch at each frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_q <= div;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/azimuth_pattern_generator.sv
// Multi-channel azimuth pattern generator. Each channel replays a stored
// SIZE-bit pattern (bit 0 first) on SIGNAL after a TRIG rising edge, one bit
// per DIV+1 clocks, in one-shot or continuous mode. Patterns are double
// buffered: LOAD fills the shadow, which is promoted to the active buffer
// only at a frame start.
// Optional build macro: AZSG_RETRIGGER_EN (TRIG edge during a frame restarts it).
module azimuth_pattern_generator
  import azimuth_pkg::*;
#(
  parameter int unsigned SIZE     = AZ_SIZE,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = AZ_DIV_W
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  input  logic                     TRIG,
  input  logic                     MODE,
  input  logic [DIV_W-1:0]         DIV,
  input  logic                     LOAD,
  input  logic [CHANNELS*SIZE-1:0] DATA,
  output logic [CHANNELS-1:0]      SIGNAL,
  output logic                     BUSY,
  output logic [clog2(SIZE)-1:0]   POS,
  output logic                     FRAME_DONE,
  output logic                     LOAD_ACK
);

  localparam int unsigned     POS_W    = clog2(SIZE);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SIZE - 1);

  az_state_e state;
  logic      trig_d;
  logic      pending;

  logic [CHANNELS-1:0][SIZE-1:0] shadow;
  logic [CHANNELS-1:0][SIZE-1:0] active;
  logic [CHANNELS-1:0][SIZE-1:0] start_pat;

  logic                start;
  logic                tick;
  logic                last_bit;
  logic                retrig;
  logic                wrap;
  logic                frame_start;
  logic [POS_W-1:0]    pos_inc;
  logic [CHANNELS-1:0] bit_first;
  logic [CHANNELS-1:0] bit_next;

  assign start    = EN & TRIG & ~trig_d;
  assign last_bit = (POS == POS_LAST);
  assign pos_inc  = POS + 1'b1;
  assign BUSY     = (state == ST_RUN);

`ifdef AZSG_RETRIGGER_EN
  assign retrig = start & (state == ST_RUN);
`else
  assign retrig = 1'b0;
`endif

  assign wrap = EN & (state == ST_RUN) & tick & last_bit & MODE;

  // Every way a frame can begin: trigger from idle, retrigger, continuous wrap
  assign frame_start = (start & (state == ST_IDLE)) | retrig | wrap;

  // A starting frame plays the shadow if a swap is pending on this edge
  assign start_pat = pending ? shadow : active;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_bitsel
    assign bit_first[g] = start_pat[g][0];
    assign bit_next[g]  = active[g][pos_inc];
  end

  // Decoded from registered state so it covers exactly the final clock of
  // bit SIZE-1; suppressed when that frame is being aborted.
  assign FRAME_DONE = EN & (state == ST_RUN) & tick & last_bit & ~retrig;

  azimuth_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (~EN),
    .load  (frame_start),
    .en    (BUSY),
    .div   (DIV),
    .tick  (tick)
  );

  // Shadow capture, pending flag and frame-boundary swap into active
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow   <= '0;
      active   <= '0;
      pending  <= 1'b0;
      LOAD_ACK <= 1'b0;
    end else begin
      if (frame_start && pending) begin
        active <= shadow;
      end
      if (LOAD) begin
        shadow <= DATA;
      end
      // A LOAD coinciding with a swap stays pending for the next frame
      pending  <= LOAD | (pending & ~frame_start);
      LOAD_ACK <= frame_start & pending;
    end
  end

  // Playback FSM: bit index, serial outputs and trigger edge history
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      SIGNAL <= '0;
      POS    <= '0;
      trig_d <= 1'b0;
    end else begin
      trig_d <= TRIG;
      if (!EN) begin
        state  <= ST_IDLE;
        SIGNAL <= '0;
        POS    <= '0;
      end else if (frame_start) begin
        state  <= ST_RUN;
        POS    <= '0;
        SIGNAL <= bit_first;
      end else begin
        case (state)
          ST_IDLE: begin
            SIGNAL <= '0;
            POS    <= '0;
          end
          ST_RUN: begin
            if (tick) begin
              if (last_bit) begin
                // One-shot end; continuous wrap is taken as a frame start
                state  <= ST_IDLE;
                SIGNAL <= '0;
                POS    <= '0;
              end else begin
                POS    <= pos_inc;
                SIGNAL <= bit_next;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            SIGNAL <= '0;
            POS    <= '0;
          end
        endcase
      end
    end
  end

endmodule
